// File: rtl/arb_req_queue.sv
// arb_req_queue
//   Front-end for a 3-port round-robin arbiter. Each port owns a small circular
//   FIFO. A non-empty FIFO raises req[i]. The arbiter answers with grant, which is
//   combinational from req. A single valid grant pops that port's head word onto
//   the registered out_* bus one cycle later.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   in_valid   per-port push request
//   in_data    per-port push data, port i at in_data[i*DW +: DW]
//   in_ready   per-port "FIFO not full", from registered occupancy only
//   req        per-port "FIFO not empty", from registered occupancy only
//   grant      one-hot (or zero) grant from the arbiter
//   out_valid  a word was popped on the previous edge
//   out_port   source port of out_data
//   out_data   popped word
//   level      per-port occupancy, port i at slice i
//   err        sticky protocol error (multi-bit grant, or grant to an empty port)
module arb_req_queue #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [2:0]                          in_valid,
    input  logic [3*DW-1:0]                     in_data,
    output logic [2:0]                          in_ready,
    output logic [2:0]                          req,
    input  logic [2:0]                          grant,
    output logic                                out_valid,
    output logic [1:0]                          out_port,
    output logic [DW-1:0]                       out_data,
    output logic [3*$clog2(DEPTH+1)-1:0]        level,
    output logic                                err
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_q   [3][DEPTH];
    logic [DW-1:0] mem_d   [3][DEPTH];
    logic [PW-1:0] wr_ptr_q [3];
    logic [PW-1:0] wr_ptr_d [3];
    logic [PW-1:0] rd_ptr_q [3];
    logic [PW-1:0] rd_ptr_d [3];
    logic [LW-1:0] lvl_q    [3];
    logic [LW-1:0] lvl_d    [3];

    logic          out_valid_q, out_valid_d;
    logic [1:0]    out_port_q,  out_port_d;
    logic [DW-1:0] out_data_q,  out_data_d;
    logic          err_q,       err_d;

    logic          grant_any;
    logic          grant_multi;
    logic          grant_ok;
    logic [2:0]    push;
    logic [2:0]    pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            in_ready[i]           = (lvl_q[i] != LW'(DEPTH));
            req[i]                = (lvl_q[i] != '0);
            level[i*LW +: LW]     = lvl_q[i];
        end
    end

    // A pop needs exactly one grant bit and that port holding data; any other
    // non-zero grant is a protocol error and pops nothing.
    always_comb begin
        grant_any   = |grant;
        grant_multi = (grant[0] & grant[1]) | (grant[0] & grant[2]) | (grant[1] & grant[2]);
        grant_ok    = grant_any && !grant_multi && |(grant & req);
    end

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        lvl_d       = lvl_q;
        out_valid_d = 1'b0;
        out_port_d  = out_port_q;
        out_data_d  = out_data_q;
        err_d       = err_q;
        push        = '0;
        pop         = '0;

        for (int i = 0; i < 3; i++) begin
            push[i] = in_valid[i] && in_ready[i];
            pop[i]  = grant_ok && grant[i];

            if (pop[i]) begin
                out_valid_d = 1'b1;
                out_port_d  = 2'(i);
                out_data_d  = mem_q[i][rd_ptr_q[i]];
                rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
            end

            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = in_data[i*DW +: DW];
                wr_ptr_d[i]           = ptr_inc(wr_ptr_q[i]);
            end

            case ({push[i], pop[i]})
                2'b10:   lvl_d[i] = lvl_q[i] + LW'(1);
                2'b01:   lvl_d[i] = lvl_q[i] - LW'(1);
                default: lvl_d[i] = lvl_q[i];
            endcase
        end

        if (grant_any && !grant_ok) begin
            err_d = 1'b1;
        end
    end

    // Storage carries no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                lvl_q[i]    <= '0;
            end
            out_valid_q <= 1'b0;
            out_port_q  <= '0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            lvl_q       <= lvl_d;
            out_valid_q <= out_valid_d;
            out_port_q  <= out_port_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_port  = out_port_q;
    assign out_data  = out_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_arb_req_queue.sv
module tb_arb_req_queue;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [2:0]           in_valid;
    logic [3*DW-1:0]      in_data;
    logic [2:0]           in_ready;
    logic [2:0]           req;
    logic [2:0]           grant;
    logic                 out_valid;
    logic [1:0]           out_port;
    logic [DW-1:0]        out_data;
    logic [3*LW-1:0]      level;
    logic                 err;

    arb_req_queue #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .req       (req),
        .grant     (grant),
        .out_valid (out_valid),
        .out_port  (out_port),
        .out_data  (out_data),
        .level     (level),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference model: plain queues per port plus the registered output values.
    logic [DW-1:0] mq [3][$];
    bit            m_ov;
    logic [1:0]    m_port;
    logic [DW-1:0] m_data;
    bit            m_err;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input logic [2:0] iv, input logic [3*DW-1:0] d,
                                input logic [2:0] g, input bit r);
        int pre [3];
        int ones;
        int gi;
        if (r) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            m_ov = 0; m_port = 0; m_data = 0; m_err = 0;
            return;
        end
        for (int i = 0; i < 3; i++) pre[i] = mq[i].size();
        ones = 0;
        gi   = 0;
        for (int i = 0; i < 3; i++) if (g[i]) begin ones++; gi = i; end
        m_ov = 0;
        if (ones == 1 && pre[gi] > 0) begin
            m_ov   = 1;
            m_port = 2'(gi);
            m_data = mq[gi].pop_front();
        end else if (ones != 0) begin
            m_err = 1;
        end
        for (int i = 0; i < 3; i++)
            if (iv[i] && pre[i] < DEPTH) mq[i].push_back(d[i*DW +: DW]);
    endtask

    task automatic check_all();
        logic [2:0]      e_rdy;
        logic [2:0]      e_req;
        logic [3*LW-1:0] e_lvl;
        for (int i = 0; i < 3; i++) begin
            e_rdy[i]          = (mq[i].size() < DEPTH);
            e_req[i]          = (mq[i].size() != 0);
            e_lvl[i*LW +: LW] = LW'(mq[i].size());
        end
        chk("in_ready",  32'(in_ready),  32'(e_rdy));
        chk("req",       32'(req),       32'(e_req));
        chk("level",     32'(level),     32'(e_lvl));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_port",  32'(out_port),  32'(m_port));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("err",       32'(err),       32'(m_err));
    endtask

    // Drive one cycle (called just after a negedge), update model, check at next negedge.
    task automatic cyc(input logic [2:0] iv, input logic [3*DW-1:0] d,
                       input logic [2:0] g, input bit r);
        rst      = r;
        in_valid = iv;
        in_data  = d;
        grant    = g;
        @(posedge clk);
        model_update(iv, d, g, r);
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [3*DW-1:0] rnd_data();
        return {8'($urandom), 8'($urandom), 8'($urandom)};
    endfunction

    function automatic logic [2:0] legal_grant();
        int cand[$];
        for (int i = 0; i < 3; i++) if (mq[i].size() != 0) cand.push_back(i);
        if (cand.size() == 0) return 3'b000;
        return 3'b001 << cand[$urandom_range(cand.size() - 1)];
    endfunction

    function automatic logic [2:0] grant_if(input int p);
        return (mq[p].size() != 0) ? (3'b001 << p) : 3'b000;
    endfunction

    initial begin
        logic [3*DW-1:0] d;
        int              sent;
        logic [2:0]      iv;
        logic [2:0]      g;

        rst = 1'b1; in_valid = '0; in_data = '0; grant = '0;
        @(negedge clk);

        // Reset held two cycles with pushes requested.
        cyc(3'b111, rnd_data(), 3'b000, 1'b1);
        cyc(3'b111, rnd_data(), 3'b000, 1'b1);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd7);

        // Order on port 0.
        cyc(3'b001, {16'h0, 8'hA1}, 3'b000, 1'b0);
        cyc(3'b001, {16'h0, 8'hA2}, 3'b000, 1'b0);
        cyc(3'b001, {16'h0, 8'hA3}, 3'b000, 1'b0);
        for (int k = 0; k < 4; k++) cyc(3'b000, '0, grant_if(0), 1'b0);
        chk("order_req0_low", 32'(req[0]), 32'd0);

        // Fill port 1 past full; fifth word is dropped.
        for (int k = 0; k < 5; k++) cyc(3'b010, {8'h0, 8'(8'hB0 + k), 8'h0}, 3'b000, 1'b0);
        chk("full_rdy1", 32'(in_ready[1]), 32'd0);
        chk("full_lvl1", 32'(level[LW +: LW]), 32'd4);
        // Push while full with grant: pop only.
        cyc(3'b010, {8'h0, 8'hBF, 8'h0}, 3'b010, 1'b0);
        chk("full_pop_rdy1", 32'(in_ready[1]), 32'd1);
        cyc(3'b000, '0, 3'b010, 1'b0);
        // Level 2: push + pop keeps level.
        cyc(3'b010, {8'h0, 8'hC0, 8'h0}, 3'b010, 1'b0);
        chk("pushpop_lvl1", 32'(level[LW +: LW]), 32'd2);
        for (int k = 0; k < 3; k++) cyc(3'b000, '0, grant_if(1), 1'b0);

        // Wrap: 10 words through port 2.
        sent = 0;
        for (int k = 0; k < 40 && (sent < 10 || mq[2].size() != 0); k++) begin
            iv = (sent < 10 && mq[2].size() < DEPTH) ? 3'b100 : 3'b000;
            g  = ($urandom_range(3) != 0) ? grant_if(2) : 3'b000;
            if (iv[2]) sent++;
            cyc(iv, {8'(8'h40 + sent), 16'h0}, g, 1'b0);
        end
        chk("wrap_sent", 32'(sent), 32'd10);

        // Errors.
        cyc(3'b011, rnd_data(), 3'b000, 1'b0);
        cyc(3'b000, '0, 3'b011, 1'b0);
        chk("err_multi", 32'(err), 32'd1);
        cyc(3'b000, '0, 3'b000, 1'b0);
        chk("err_sticky", 32'(err), 32'd1);
        cyc(3'b000, '0, 3'b100, 1'b0);

        // Reset mid-burst, then grants find nothing.
        cyc(3'b000, '0, 3'b000, 1'b1);
        for (int k = 0; k < 3; k++) cyc(3'b001, rnd_data(), 3'b000, 1'b0);
        cyc(3'b001, rnd_data(), 3'b000, 1'b1);
        chk("mid_rst_lvl", 32'(level), 32'd0);
        cyc(3'b000, '0, 3'b001, 1'b0);

        // Randomized traffic.
        cyc(3'b000, '0, 3'b000, 1'b1);
        for (int k = 0; k < 3000; k++) begin
            iv = 3'($urandom);
            case ($urandom_range(99))
                0, 1:        g = 3'($urandom);
                2, 3, 4, 5:  g = 3'b000;
                default:     g = legal_grant();
            endcase
            cyc(iv, rnd_data(), g, ($urandom_range(149) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
